dec_fwd_stage: RTL and testbench

Parametrised decode stage for the MultiCPU pipeline, sitting between fetch and execute. It holds the IF/ID pipeline register and a 2R1W register file, and extracts source and destination fields. It resolves read-after-write hazards either by E/M/W forwarding with a load-use stall, or by a scoreboard that stalls until writeback. Both sides use valid/ready handshakes, and a flush input squashes wrong-path instructions.

---
 rtl/dec_pkg.sv | 61 ++++++
 rtl/dec_regfile.sv | 53 +++++
 rtl/dec_fwd_stage.sv | 180 ++++++++++++++++++
 tb/tb_dec_fwd_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared decode definitions for the MultiCPU decode stage: opcode groups, field
// extraction and forwarding source selects.
package dec_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;

    // Opcode groups keyed on opcode[5:3]
    localparam logic [2:0] OPG_IMM   = 3'b001;
    localparam logic [2:0] OPG_LOAD  = 3'b100;
    localparam logic [2:0] OPG_STORE = 3'b101;

    localparam logic [5:0] FUNCT_JR  = 6'b001000;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        SRC_RF,
        SRC_WB,
        SRC_MEM,
        SRC_EX
    } fwd_src_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
        logic       uses_rs;
        logic       uses_rt;
    } dec_fields_t;

    function automatic dec_fields_t decode(input logic [31:0] inst, input logic [4:0] ra_idx);
        dec_fields_t f;
        logic [5:0]  op;
        logic        is_rtype;
        logic        writes;
        op       = inst[31:26];
        is_rtype = (op == OP_RTYPE);
        f.rs     = inst[25:21];
        f.rt     = inst[20:16];
        if (is_rtype) begin
            f.rd = inst[15:11];
        end else if (op == OP_JAL) begin
            f.rd = ra_idx;
        end else begin
            f.rd = inst[20:16];
        end
        f.is_load = (op[5:3] == OPG_LOAD);
        writes    = (is_rtype && inst[5:0] != FUNCT_JR) || (op[5:3] == OPG_IMM)
                    || f.is_load || (op == OP_JAL);
        f.we      = writes && (f.rd != REG_ZERO);
        f.uses_rs = (op != OP_J) && (op != OP_JAL);
        f.uses_rt = is_rtype || (op[5:3] == OPG_STORE) || (op == OP_BEQ) || (op == OP_BNE);
        return f;
    endfunction

endpackage

// File: rtl/dec_regfile.sv
// 2R1W architectural register file, asynchronous read with writeback bypass;
// register 0 is hard-wired to zero.
module dec_regfile
    import dec_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != ZERO_IDX) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == ZERO_IDX) begin
            rdata1 = '0;
        end else if (we && waddr == raddr1) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == ZERO_IDX) begin
            rdata2 = '0;
        end else if (we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/dec_fwd_stage.sv
// Decode stage: IF/ID register, field decode, register file and RAW hazard handling.
// DEC_FWD_EN selects E/M/W forwarding with load-use stall; otherwise a busy scoreboard.
module dec_fwd_stage
    import dec_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int RA_IDX = 31,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [AW-1:0]   id_rs,
    output logic [AW-1:0]   id_rt,
    output logic [AW-1:0]   id_rd,
    output logic            id_we,
    output logic            id_is_load,
    output logic [XLEN-1:0] id_rd1,
    output logic [XLEN-1:0] id_rd2,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            hazard;
    logic            capture;
    logic            handoff;
    dec_fields_t     f;
    logic [AW-1:0]   rs_a;
    logic [AW-1:0]   rt_a;
    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    assign f    = decode(inst_q, 5'(RA_IDX));
    assign rs_a = AW'(f.rs);
    assign rt_a = AW'(f.rt);
    assign rd_a = AW'(f.rd);

    assign id_valid   = valid_q & ~hazard & ~flush;
    assign if_ready   = ~valid_q | (id_ready & ~hazard);
    assign capture    = if_valid & if_ready & ~flush;
    assign handoff    = id_valid & id_ready;

    assign id_pc      = pc_q;
    assign id_inst    = inst_q;
    assign id_rs      = rs_a;
    assign id_rt      = rt_a;
    assign id_rd      = rd_a;
    assign id_we      = f.we;
    assign id_is_load = f.is_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            pc_q    <= if_pc;
            inst_q  <= if_inst;
        end else if (handoff) begin
            valid_q <= 1'b0;
        end
    end

    dec_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs_a),
        .raddr2 (rt_a),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

`ifdef DEC_FWD_EN
    logic [AW-1:0]   src    [2];
    logic [XLEN-1:0] rf_val [2];
    fwd_src_e        sel    [2];
    logic [XLEN-1:0] opnd   [2];
    logic            use_hit[2];

    assign src[0]    = rs_a;
    assign src[1]    = rt_a;
    assign rf_val[0] = rf_rd1;
    assign rf_val[1] = rf_rd2;

    // A load in E has no data yet, so it is skipped here and stalls via hazard.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            sel[i] = SRC_RF;
            if (src[i] != ZERO_IDX) begin
                if (ex_we && !ex_is_load && ex_rd == src[i]) begin
                    sel[i] = SRC_EX;
                end else if (mem_we && mem_rd == src[i]) begin
                    sel[i] = SRC_MEM;
                end else if (wb_we && wb_rd == src[i]) begin
                    sel[i] = SRC_WB;
                end
            end
            case (sel[i])
                SRC_EX:  opnd[i] = ex_data;
                SRC_MEM: opnd[i] = mem_data;
                SRC_WB:  opnd[i] = wb_data;
                default: opnd[i] = rf_val[i];
            endcase
        end
    end

    assign use_hit[0] = f.uses_rs && rs_a != ZERO_IDX && rs_a == ex_rd;
    assign use_hit[1] = f.uses_rt && rt_a != ZERO_IDX && rt_a == ex_rd;
    assign hazard     = ex_we & ex_is_load & (use_hit[0] | use_hit[1]);
    assign id_rd1     = opnd[0];
    assign id_rd2     = opnd[1];
`else
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] id_set;
    logic [NREG-1:0] busy_now;
    logic            unused_fwd_inputs;

    always_comb begin
        wb_clr = '0;
        id_set = '0;
        if (wb_we) begin
            wb_clr[wb_rd] = 1'b1;
        end
        if (handoff && f.we) begin
            id_set[rd_a] = 1'b1;
        end
    end

    // A writeback this cycle releases its register immediately via the regfile bypass.
    assign busy_now = busy_q & ~wb_clr;
    assign hazard   = (f.uses_rs && rs_a != ZERO_IDX && busy_now[rs_a])
                    | (f.uses_rt && rt_a != ZERO_IDX && busy_now[rt_a]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_now | id_set;
        end
    end

    assign id_rd1 = rf_rd1;
    assign id_rd2 = rf_rd2;
    assign unused_fwd_inputs = ^{ex_we, ex_is_load, ex_rd, ex_data, mem_we, mem_rd, mem_data};
`endif

endmodule

// File: tb/tb_dec_fwd_stage.sv
// Self-checking bench for dec_fwd_stage: rule-level model compared every cycle
// plus directed vectors with literal expectations; follows the DEC_FWD_EN build.
module tb_dec_fwd_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;
    logic [AW-1:0]   id_rs, id_rt, id_rd;
    logic            id_we, id_is_load;
    logic [XLEN-1:0] id_rd1, id_rd2;
    logic            ex_we, ex_is_load;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            mem_we;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_fwd_stage #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .RA_IDX (31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_we      (id_we),
        .id_is_load (id_is_load),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;

    function automatic logic [4:0] m_dest(input logic [31:0] i);
        case (i[31:26])
            6'd0:    return i[15:11];
            6'd3:    return 5'd31;
            default: return i[20:16];
        endcase
    endfunction

    function automatic bit m_writes(input logic [31:0] i);
        logic [5:0] op;
        bit w;
        op = i[31:26];
        w  = (op == 6'd0 && i[5:0] != 6'h08) || op[5:3] == 3'b001 || op[5:3] == 3'b100 || op == 6'd3;
        return w && m_dest(i) != 5'd0;
    endfunction

    function automatic bit m_uses_rs(input logic [31:0] i);
        return i[31:26] != 6'd2 && i[31:26] != 6'd3;
    endfunction

    function automatic bit m_uses_rt(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return op == 6'd0 || op[5:3] == 3'b101 || op == 6'd4 || op == 6'd5;
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
`ifdef DEC_FWD_EN
        if (ex_we && !ex_is_load && ex_rd == s) return ex_data;
        if (mem_we && mem_rd == s) return mem_data;
`endif
        if (wb_we && wb_rd == s) return wb_data;
        return m_regs[s];
    endfunction

    function automatic bit m_src_blocked(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
`ifdef DEC_FWD_EN
        return ex_we && ex_is_load && ex_rd == s;
`else
        return m_busy[s] && !(wb_we && wb_rd == s);
`endif
    endfunction

    task automatic m_eval(output bit hz, output bit ev, output bit er);
        hz = (m_uses_rs(m_inst) && m_src_blocked(m_inst[25:21]))
          || (m_uses_rt(m_inst) && m_src_blocked(m_inst[20:16]));
        ev = m_valid && !hz && !flush;
        er = !m_valid || (id_ready && !hz);
    endtask

    always @(posedge clk or posedge rst) begin
        bit hz, ev, er;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            m_valid = 1'b0;
            m_pc    = 32'd0;
            m_inst  = 32'd0;
        end else begin
            m_eval(hz, ev, er);
            if (wb_we) m_busy[wb_rd] = 1'b0;
            if (ev && id_ready && m_writes(m_inst)) m_busy[m_dest(m_inst)] = 1'b1;
            if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (flush) begin
                m_valid = 1'b0;
            end else if (if_valid && er) begin
                m_valid = 1'b1;
                m_pc    = if_pc;
                m_inst  = if_inst;
            end else if (ev && id_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        bit hz, ev, er;
        if (!rst) begin
            m_eval(hz, ev, er);
            chk("model_id_valid", {31'd0, id_valid}, {31'd0, ev});
            chk("model_if_ready", {31'd0, if_ready}, {31'd0, er});
            if (m_valid) begin
                chk("model_id_pc", id_pc, m_pc);
                chk("model_id_inst", id_inst, m_inst);
                chk("model_id_rd", {27'd0, id_rd}, {27'd0, m_dest(m_inst)});
                chk("model_id_we", {31'd0, id_we}, {31'd0, m_writes(m_inst)});
                chk("model_id_is_load", {31'd0, id_is_load}, {31'd0, m_inst[31:29] == 3'b100});
                chk("model_id_rd1", id_rd1, m_operand(m_inst[25:21]));
                chk("model_id_rd2", id_rd2, m_operand(m_inst[20:16]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
        if_valid = 1'b1;
        if_pc    = pc;
        if_inst  = inst;
        cyc();
        if_valid = 1'b0;
    endtask

    task automatic drain();
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0; id_ready = 1'b0;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
        mem_we = 1'b0; mem_rd = '0; mem_data = '0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("reset_id_valid", {31'd0, id_valid}, 32'd0);
        chk("reset_if_ready", {31'd0, if_ready}, 32'd1);
        chk("reset_id_rd1", id_rd1, 32'd0);
        chk("reset_id_rd2", id_rd2, 32'd0);
        chk("reset_id_inst", id_inst, 32'd0);

        // addi $2,$0,5
        feed(32'h100, 32'h20020005);
        #3;
        chk("addi_id_valid", {31'd0, id_valid}, 32'd1);
        chk("addi_id_rd", {27'd0, id_rd}, 32'd2);
        chk("addi_id_we", {31'd0, id_we}, 32'd1);
        drain();
        #3 chk("addi_handoff", {31'd0, id_valid}, 32'd0);

`ifdef DEC_FWD_EN
        // add $3,$1,$1 with E and M both writing $1
        feed(32'h104, 32'h00211820);
        ex_we = 1'b1; ex_rd = 5'd1; ex_data = 32'd7;
        mem_we = 1'b1; mem_rd = 5'd1; mem_data = 32'd9;
        #3;
        chk("fwd_ex_rd1", id_rd1, 32'd7);
        chk("fwd_ex_rd2", id_rd2, 32'd7);
        ex_we = 1'b0;
        #2;
        chk("fwd_mem_rd1", id_rd1, 32'd9);
        chk("fwd_mem_rd2", id_rd2, 32'd9);
        mem_we = 1'b0;
        drain();

        // add $5,$4,$0 behind lw $4
        feed(32'h108, 32'h00802820);
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; id_ready = 1'b1;
        #3;
        chk("lu_stall_valid", {31'd0, id_valid}, 32'd0);
        chk("lu_stall_ready", {31'd0, if_ready}, 32'd0);
        cyc();
        ex_we = 1'b0; ex_is_load = 1'b0;
        mem_we = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        #3;
        chk("lu_release_valid", {31'd0, id_valid}, 32'd1);
        chk("lu_release_ready", {31'd0, if_ready}, 32'd1);
        chk("lu_mem_rd1", id_rd1, 32'h44);
        cyc();
        id_ready = 1'b0; mem_we = 1'b0;
`else
        // add $6,$1,$1 then add $7,$6,$6
        id_ready = 1'b1;
        if_valid = 1'b1; if_pc = 32'h104; if_inst = 32'h00213020;
        cyc();
        if_pc = 32'h108; if_inst = 32'h00C63820;
        #3;
        chk("sb_add6_valid", {31'd0, id_valid}, 32'd1);
        chk("sb_add6_ready", {31'd0, if_ready}, 32'd1);
        cyc();
        if_valid = 1'b0;
        #3;
        chk("sb_stall_valid", {31'd0, id_valid}, 32'd0);
        chk("sb_stall_ready", {31'd0, if_ready}, 32'd0);
        cyc();
        #3 chk("sb_stall2_valid", {31'd0, id_valid}, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h11;
        #2;
        chk("sb_wb_valid", {31'd0, id_valid}, 32'd1);
        chk("sb_wb_rd1", id_rd1, 32'h11);
        chk("sb_wb_rd2", id_rd2, 32'h11);
        cyc();
        wb_we = 1'b0; id_ready = 1'b0;
        #3 chk("sb_add7_gone", {31'd0, id_valid}, 32'd0);
`endif

        // flush with ID full and fetch offering
        feed(32'h200, 32'h20080001);
        if_valid = 1'b1; if_pc = 32'h204; if_inst = 32'h20090002;
        flush = 1'b1; id_ready = 1'b1;
        #3 chk("flush_same_valid", {31'd0, id_valid}, 32'd0);
        cyc();
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        #3;
        chk("flush_next_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_next_ready", {31'd0, if_ready}, 32'd1);
        chk("flush_discard", id_inst, 32'h20080001);
        // add $10,$8,$8 must not stall on the squashed writer of $8
        feed(32'h208, 32'h01085020);
        #3 chk("flush_no_busy", {31'd0, id_valid}, 32'd1);
        drain();

        // jal
        feed(32'h300, 32'h0C000010);
        #3;
        chk("jal_id_rd", {27'd0, id_rd}, 32'd31);
        chk("jal_id_we", {31'd0, id_we}, 32'd1);
        drain();

        // addi $0,$0,3 writes nothing
        feed(32'h304, 32'h20000003);
        #3 chk("zero_dest_we", {31'd0, id_we}, 32'd0);
        drain();

        // add $11,$0,$0 while writeback targets $0
        feed(32'h308, 32'h00005820);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        #3 chk("zero_bypass_rd1", id_rd1, 32'd0);
        cyc();
        wb_we = 1'b0;
        #3;
        chk("zero_after_rd1", id_rd1, 32'd0);
        chk("zero_after_rd2", id_rd2, 32'd0);
        drain();

        // lw $12,0($0)
        feed(32'h30C, 32'h8C0C0000);
        #3;
        chk("lw_is_load", {31'd0, id_is_load}, 32'd1);
        chk("lw_id_rd", {27'd0, id_rd}, 32'd12);

        // asynchronous reset while ID is full
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, if_ready}, 32'd1);
        chk("async_rst_inst", id_inst, 32'd0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
